// File: rtl/count_ctrl.sv
// Purpose : start/stop/pause/step control and prescaled count strobe for a WIDTH-bit counter.
// Latency : commands act on the next clock edge; enable is a registered tick gated combinationally by the terminal-value hit.
// Backpress: none; commands are single-cycle levels, and a stalled counter is expressed as enable held low.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   start/stop/step   - run control commands (priority clear_req > stop > start > step)
//   clear_req         - clear the counter and return to IDLE
//   div               - RUN produces one enable every div+1 cycles
//   stop_at_en/_val   - halt counting when q_in reaches stop_at_val
//   q_in              - live counter value
//   enable, clr       - count strobe and one-cycle synchronous clear to the counter
//   state, done       - 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; done while in DONE
module count_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  clear_req,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  stop_at_en,
    input  logic [WIDTH-1:0]      stop_at_val,
    input  logic [WIDTH-1:0]      q_in,
    output logic                  enable,
    output logic                  clr,
    output logic [1:0]            state,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tick_q, tick_d;
    logic                  clr_q, clr_d;
    logic                  hit;

    assign hit    = stop_at_en && (q_in == stop_at_val);
    // Gating the registered tick with the live hit keeps the counter from
    // ever stepping past the terminal value, including on single steps.
    assign enable = tick_q & ~hit;
    assign clr    = clr_q;
    assign state  = state_q;
    assign done   = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        tick_d    = 1'b0;
        clr_d     = 1'b0;

        if (clear_req) begin
            clr_d     = 1'b1;
            pre_cnt_d = '0;
            state_d   = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // stop outranks start, so a stop here swallows the cycle.
                    if (!stop) begin
                        if (start) begin
                            state_d   = ST_RUN;
                            pre_cnt_d = '0;
                        end else if (step) begin
                            tick_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    // While our clear pulse is out, q_in still shows the old
                    // value; ignore hit so a restart from DONE is not undone.
                    end else if (hit && !clr_q) begin
                        state_d   = ST_DONE;
                        pre_cnt_d = '0;
                    end else if (pre_cnt_q == div) begin
                        tick_d    = 1'b1;
                        pre_cnt_d = '0;
                    end else begin
                        // Wraps naturally if div was lowered below pre_cnt.
                        pre_cnt_d = pre_cnt_q + PRE_ONE;
                    end
                end
                ST_PAUSE: begin
                    if (!stop) begin
                        if (start) begin
                            state_d = ST_RUN;
                        end else if (step) begin
                            tick_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!stop && start) begin
                        clr_d     = 1'b1;
                        state_d   = ST_RUN;
                        pre_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Purpose : directed bench for count_ctrl driving a 4-bit counter model.
// Latency : inputs change 1ns after a rising edge; outputs sampled there too.
// Backpress: not applicable.
module tb_count_ctrl;

    logic       clk;
    logic       reset;
    logic       start, stop, step, clear_req;
    logic [7:0] div;
    logic       stop_at_en;
    logic [3:0] stop_at_val;
    logic [3:0] q_cnt;
    logic       enable, clr, done;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    count_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .clear_req   (clear_req),
        .div         (div),
        .stop_at_en  (stop_at_en),
        .stop_at_val (stop_at_val),
        .q_in        (q_cnt),
        .enable      (enable),
        .clr         (clr),
        .state       (state),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The downstream counter: synchronous clear, counts on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      q_cnt <= 4'd0;
        else if (clr)    q_cnt <= 4'd0;
        else if (enable) q_cnt <= q_cnt + 4'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1; cyc(); clear_req = 1'b0;
        check_val("clr_pulse", clr, 1);
        check_val("clr_state", state, 0);
        check_val("clr_enable", enable, 0);
        cyc();
        check_val("clr_one_cycle", clr, 0);
        check_val("clr_q_zero", q_cnt, 0);
    endtask

    initial begin
        reset = 1'b0; start = 0; stop = 0; step = 0; clear_req = 0;
        div = 8'd0; stop_at_en = 0; stop_at_val = 4'd0;
        #12;
        check_val("rst_state", state, 0);
        check_val("rst_enable", enable, 0);
        check_val("rst_clr", clr, 0);
        check_val("rst_done", done, 0);
        reset = 1'b1;
        cyc();
        check_val("idle_wait", state, 0);

        // ---- div=0 free run, wrap, async reset mid-run ----
        start = 1; cyc(); start = 0;
        check_val("run_state", state, 1);
        check_val("run_first_no_en", enable, 0);
        for (int k = 1; k <= 17; k++) begin
            cyc();
            check_val("div0_enable", enable, 1);
            check_val("div0_q", q_cnt, (k - 1) % 16);
        end
        reset = 1'b0; #1;
        check_val("async_rst_enable", enable, 0);
        check_val("async_rst_state", state, 0);
        #2 reset = 1'b1;
        cyc();

        // ---- div=3: one enable every 4 cycles ----
        div = 8'd3;
        start = 1; cyc(); start = 0;
        for (int k = 1; k <= 21; k++) begin
            cyc();
            check_val("div3_enable", enable, (k % 4) == 0);
        end
        check_val("div3_q", q_cnt, 5);
        pulse_clear();

        // ---- terminal value 9 ----
        div = 8'd0; stop_at_en = 1; stop_at_val = 4'd9;
        start = 1; cyc(); start = 0;
        for (int k = 1; k <= 9; k++) cyc();
        check_val("term_q8_en", enable, 1);
        cyc();
        check_val("term_q9", q_cnt, 9);
        check_val("term_no_en_at_9", enable, 0);
        check_val("term_still_run", state, 1);
        cyc();
        check_val("term_done_state", state, 3);
        check_val("term_done", done, 1);
        check_val("term_hold_q", q_cnt, 9);
        step = 1; cyc(); step = 0;
        check_val("done_step_ignored", enable, 0);
        cyc();
        check_val("done_step_q", q_cnt, 9);
        start = 1; cyc(); start = 0;
        check_val("restart_clr", clr, 1);
        check_val("restart_state", state, 1);
        cyc();
        check_val("restart_clr_gone", clr, 0);
        check_val("restart_q0", q_cnt, 0);
        check_val("restart_en", enable, 1);
        check_val("restart_state2", state, 1);
        cyc();
        check_val("restart_q1", q_cnt, 1);
        stop_at_en = 0;
        pulse_clear();

        // ---- div=4: pause, step, resume phase ----
        div = 8'd4;
        start = 1; cyc(); start = 0;
        for (int k = 1; k <= 6; k++) cyc();
        check_val("pause_pre_q", q_cnt, 1);
        stop = 1; cyc(); stop = 0;
        check_val("pause_state", state, 2);
        check_val("pause_en", enable, 0);
        cyc(); cyc();
        check_val("pause_hold_q", q_cnt, 1);
        check_val("pause_hold_state", state, 2);
        for (int s = 0; s < 2; s++) begin
            step = 1; cyc(); step = 0;
            check_val("step_en", enable, 1);
            cyc();
            check_val("step_en_one", enable, 0);
            check_val("step_q", q_cnt, 2 + s);
            check_val("step_state", state, 2);
        end
        // pre_cnt was frozen at 1, so the tick lands in RUN cycle 5, not 6.
        start = 1; cyc(); start = 0;
        check_val("resume_state", state, 1);
        for (int j = 1; j <= 5; j++) begin
            cyc();
            check_val("resume_phase_en", enable, j == 4);
        end
        check_val("resume_q", q_cnt, 4);
        pulse_clear();

        // ---- start + clear_req together during RUN ----
        div = 8'd0;
        start = 1; cyc(); start = 0;
        cyc(); cyc();
        start = 1; clear_req = 1; cyc(); start = 0; clear_req = 0;
        check_val("sc_clr", clr, 1);
        check_val("sc_state", state, 0);
        check_val("sc_enable", enable, 0);
        cyc();
        check_val("sc_clr_one", clr, 0);
        check_val("sc_enable2", enable, 0);
        check_val("sc_q", q_cnt, 0);

        // ---- stop and hit in the same cycle ----
        stop_at_en = 1; stop_at_val = 4'd3;
        start = 1; cyc(); start = 0;
        cyc(); cyc(); cyc();
        check_val("sh_q2", q_cnt, 2);
        cyc();
        check_val("sh_q3", q_cnt, 3);
        check_val("sh_en_gated", enable, 0);
        stop = 1; cyc(); stop = 0;
        check_val("sh_state", state, 2);
        check_val("sh_enable", enable, 0);
        check_val("sh_done", done, 0);
        check_val("sh_q_hold", q_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Control stage directly upstream of the 4-bit synchronous counter.
- Generates the counter's `enable` strobe from a programmable prescaler and a start/stop/pause/step state machine.
- Generates a synchronous clear pulse that drives the counter's clear/reset input.
- Watches the counter value `q_in` so it can halt counting exactly at a programmed terminal value.

Parameters:
- WIDTH, 4, counter width; width of `q_in` and `stop_at_val`.
- PRESCALE_W, 8, width of the prescaler divide setting `div`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  start/resume command, level-sampled each cycle.
- stop  input  1  pause command.
- step  input  1  single-step command; one enable pulse when not running.
- clear_req  input  1  request counter clear and return to IDLE.
- div  input  PRESCALE_W  in RUN, enable asserts once every div+1 cycles.
- stop_at_en  input  1  enables terminal-value halt.
- stop_at_val  input  WIDTH  terminal value.
- q_in  input  WIDTH  current counter output.
- enable  output  1  count strobe to the counter.
- clr  output  1  one-cycle synchronous clear to the counter.
- state  output  2  0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = DONE.
- done  output  1  high while state == DONE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; enable = 0, clr = 0, done = 0.
  - Prescaler count `pre_cnt` = 0; internal tick register = 0.
  - Takes effect immediately, including mid-count; on release the block waits in IDLE.
- Hit term: hit = stop_at_en && (q_in == stop_at_val). Compared at full WIDTH, no wrap arithmetic.
- enable = tick_r & ~hit:
  - tick_r is registered; the hit gating is combinational.
  - The counter therefore never advances past stop_at_val.
- Command priority within a cycle: clear_req > stop > start > step. Only the highest-priority asserted command acts.
- clear_req (any state):
  - Next cycle: clr = 1 for exactly one cycle, tick_r = 0, pre_cnt = 0, state = IDLE.
  - A held clear_req keeps clr high every cycle.
- IDLE:
  - start: next state RUN, pre_cnt = 0.
  - step: tick_r = 1 for one cycle, state stays IDLE.
- RUN:
  - pre_cnt increments each cycle.
  - When pre_cnt == div: tick_r = 1 next cycle and pre_cnt = 0. div = 0 gives tick_r high every cycle.
  - stop: next state PAUSE, tick_r = 0, pre_cnt holds.
  - hit sampled high: next state DONE, tick_r = 0, pre_cnt = 0. The hit check is made before the stop check only when stop is low; stop wins if both.
- PAUSE:
  - pre_cnt frozen.
  - start: next state RUN; the prescaler resumes from the held pre_cnt.
  - step: one tick_r pulse, state stays PAUSE.
  - stop: no effect.
- DONE:
  - done = 1, tick_r = 0.
  - start: clr = 1 for one cycle, state = RUN, pre_cnt = 0; counting resumes from 0.
  - step: ignored.
- step pulses remain subject to hit gating. A step when q_in == stop_at_val (with stop_at_en = 1) produces no enable.
- Commands are level-sensitive, with no edge detection. The upstream logic presents single-cycle commands.
- The prescaler compare uses the live `div`. Changing `div` mid-run takes effect on the next compare. If the new div is below pre_cnt, pre_cnt wraps modulo 2^PRESCALE_W before matching.

Test Plan:
- Reset then start, div = 0, stop_at_en = 0, counter attached:
  - Required: enable high every cycle from the 2nd cycle after start.
  - q runs 0..15, wraps to 0.
  - Asserting reset = 0 mid-run forces enable = 0 and state = 0 immediately.
- div = 3, start:
  - Required: enable pulses one cycle in every 4.
  - After 20 cycles in RUN, q = 5.
- div = 0, stop_at_en = 1, stop_at_val = 9, start:
  - Required: q stops at exactly 9; enable is never high while q = 9.
  - state = 3 and done = 1 the cycle after q reaches 9.
  - A later start produces a clr pulse, q = 0, then counting resumes.
- div = 4; start, run 7 cycles, stop:
  - Required: state = 2 and pre_cnt holds.
  - Two step pulses give exactly 2 enable pulses (q + 2).
  - start resumes; the first enable arrives at the phase the prescaler left off.
- start and clear_req in the same cycle during RUN:
  - Required: clr = 1 for one cycle and state = 0; enable stays 0.
- stop and a hit in the same cycle:
  - Required: state = 2, not 3; enable = 0.
